// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronises and debounces the raw POR flag, then
// releases NUM_CH reset domains in order; also handles software warm reset.
module por_reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 8,
  parameter int STAGE_DLY   = 16,
  parameter int SW_HOLD_CYC = 32
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              POR_N_I,
  input  logic              SW_RST_REQ_I,
  input  logic              CAUSE_CLR_I,
  output logic [NUM_CH-1:0] RST_N_O,
  output logic              READY_O,
  output logic [1:0]        CAUSE_O,
  output logic [2:0]        STATE_O
);
  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int DW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
  localparam int HW = (SW_HOLD_CYC > 1) ? $clog2(SW_HOLD_CYC) : 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DLY - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SW_HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    FILTER  = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    SWHOLD  = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   por_s;
  logic [1:0]             cause_set;
  logic [FW-1:0]          fcnt;
  logic [DW-1:0]          dcnt;
  logic [HW-1:0]          hcnt;
  logic [IW-1:0]          idx;
  logic [NUM_CH-1:0]      rst_n;
  logic                   ready;
  logic [1:0]             cause;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], POR_N_I};
  end

  assign por_s = sync[SYNC_STAGES-1];

  // A power loss outranks a software request raised in the same cycle.
  always_comb begin
    cause_set    = 2'b00;
    cause_set[0] = !por_s && (state inside {RELEASE, RUN, SWHOLD});
    cause_set[1] = por_s && (state == RUN) && SW_RST_REQ_I;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= ASSERT;
      rst_n <= '0;
      ready <= 1'b0;
      cause <= 2'b01;
      fcnt  <= '0;
      dcnt  <= '0;
      hcnt  <= '0;
      idx   <= '0;
    end else begin
      cause <= (cause & ~{2{CAUSE_CLR_I}}) | cause_set;
      case (state)
        ASSERT: begin
          rst_n <= '0;
          ready <= 1'b0;
          fcnt  <= '0;
          if (por_s) state <= FILTER;
        end
        FILTER: begin
          if (!por_s) begin
            state <= ASSERT;
            fcnt  <= '0;
          end else if (fcnt == FILT_LAST) begin
            state <= RELEASE;
            fcnt  <= '0;
            dcnt  <= '0;
            idx   <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!por_s) begin
            state <= ASSERT;
            rst_n <= '0;
            ready <= 1'b0;
          end else if (dcnt == DLY_LAST) begin
            dcnt       <= '0;
            rst_n[idx] <= 1'b1;
            if (idx == IDX_LAST) begin
              state <= RUN;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        RUN: begin
          if (!por_s) begin
            state <= ASSERT;
            rst_n <= '0;
            ready <= 1'b0;
          end else if (SW_RST_REQ_I) begin
            state <= SWHOLD;
            rst_n <= '0;
            ready <= 1'b0;
            hcnt  <= '0;
          end else begin
            ready <= 1'b1;
          end
        end
        SWHOLD: begin
          if (!por_s) begin
            state <= ASSERT;
          end else if (hcnt == HOLD_LAST) begin
            state <= RELEASE;
            hcnt  <= '0;
            dcnt  <= '0;
            idx   <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= ASSERT;
          rst_n <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign RST_N_O = rst_n;
  assign READY_O = ready;
  assign CAUSE_O = cause;
  assign STATE_O = state;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Bench for por_reset_sequencer: a default instance and a minimal-parameter
// instance share stimulus and are compared against a time-based reference model.
module tb_por_reset_sequencer;

  typedef struct {
    int nch, ss, filt, dly, hold;
  } cfg_t;

  // Power is "down" (mode 0), "sequencing" since t edges ago (mode 1), or held
  // by a software reset for h edges (mode 2).
  typedef struct {
    logic [7:0] sync;
    int         mode;
    int         streak;
    int         t;
    int         h;
    logic [1:0] cause;
  } model_t;

  typedef struct {
    logic       por, sw, clr;
    int         n;
    logic [3:0] rstn;
    logic       rdy;
    logic [1:0] cause;
    logic [2:0] st;
  } vec_t;

  localparam int NV = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       por = 1'b0;
  logic       sw  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] rst_n0;
  logic       ready0;
  logic [1:0] cause0;
  logic [2:0] state0;
  logic [0:0] rst_n1;
  logic       ready1;
  logic [1:0] cause1;
  logic [2:0] state1;

  int     checks = 0;
  int     errors = 0;
  int     ecount = 0;
  int     rise0[4];
  int     rdy0_e;
  int     rise1;
  int     rdy1_e;
  cfg_t   c0, c1;
  model_t m0, m1;
  vec_t   tbl[NV];

  por_reset_sequencer dut (
    .CLK_I(clk), .RST_I(rst), .POR_N_I(por), .SW_RST_REQ_I(sw), .CAUSE_CLR_I(clr),
    .RST_N_O(rst_n0), .READY_O(ready0), .CAUSE_O(cause0), .STATE_O(state0)
  );

  por_reset_sequencer #(
    .NUM_CH(1), .SYNC_STAGES(2), .FILT_CYC(1), .STAGE_DLY(1), .SW_HOLD_CYC(4)
  ) dut1 (
    .CLK_I(clk), .RST_I(rst), .POR_N_I(por), .SW_RST_REQ_I(sw), .CAUSE_CLR_I(clr),
    .RST_N_O(rst_n1), .READY_O(ready1), .CAUSE_O(cause1), .STATE_O(state1)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t m;
    m.sync = '0; m.mode = 0; m.streak = 0; m.t = 0; m.h = 0; m.cause = 2'b01;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, cfg_t c, logic p, logic s, logic k);
    model_t     n = m;
    logic       ps = m.sync[c.ss-1];
    logic [1:0] set = 2'b00;
    if (!ps) begin
      if (m.mode != 0) set[0] = 1'b1;
      n.mode = 0;
      n.streak = 0;
    end else if (m.mode == 0) begin
      n.streak = m.streak + 1;
      if (n.streak == c.filt + 1) begin
        n.mode = 1; n.t = 0; n.streak = 0;
      end
    end else if (m.mode == 1) begin
      if (s && m.t >= c.nch * c.dly) begin
        n.mode = 2; n.h = 0; set[1] = 1'b1;
      end else if (m.t < 1000000) begin
        n.t = m.t + 1;
      end
    end else begin
      if (m.h == c.hold - 1) begin
        n.mode = 1; n.t = 0;
      end else begin
        n.h = m.h + 1;
      end
    end
    n.cause = (m.cause & ~{k, k}) | set;
    n.sync  = {m.sync[6:0], p};
    return n;
  endfunction

  function automatic logic [31:0] exp_rstn(model_t m, cfg_t c);
    logic [31:0] r = '0;
    for (int k = 0; k < c.nch; k++) r[k] = (m.mode == 1) && (m.t >= c.dly * (k + 1));
    return r;
  endfunction

  function automatic logic [31:0] exp_ready(model_t m, cfg_t c);
    return 32'((m.mode == 1) && (m.t >= c.nch * c.dly + 1));
  endfunction

  function automatic logic [31:0] exp_state(model_t m, cfg_t c);
    if (m.mode == 0) return (m.streak > 0) ? 32'd1 : 32'd0;
    if (m.mode == 1) return (m.t >= c.nch * c.dly) ? 32'd3 : 32'd2;
    return 32'd4;
  endfunction

  function automatic vec_t mk(logic p, logic s, logic k, int n, logic [3:0] rn,
                              logic rd, logic [1:0] ca, logic [2:0] st);
    vec_t v;
    v.por = p; v.sw = s; v.clr = k; v.n = n;
    v.rstn = rn; v.rdy = rd; v.cause = ca; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m0 = model_step(m0, c0, por, sw, clr);
    m1 = model_step(m1, c1, por, sw, clr);
    ecount++;
    #1;
    for (int k = 0; k < 4; k++) if (rise0[k] == 0 && rst_n0[k]) rise0[k] = ecount;
    if (rdy0_e == 0 && ready0) rdy0_e = ecount;
    if (rise1 == 0 && rst_n1[0]) rise1 = ecount;
    if (rdy1_e == 0 && ready1) rdy1_e = ecount;
    check("d0 rst_n", 32'(rst_n0), exp_rstn(m0, c0));
    check("d0 ready", 32'(ready0), exp_ready(m0, c0));
    check("d0 cause", 32'(cause0), 32'(m0.cause));
    check("d0 state", 32'(state0), exp_state(m0, c0));
    check("d1 rst_n", 32'(rst_n1), exp_rstn(m1, c1));
    check("d1 ready", 32'(ready1), exp_ready(m1, c1));
    check("d1 cause", 32'(cause1), 32'(m1.cause));
    check("d1 state", 32'(state1), exp_state(m1, c1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; por = 1'b0; sw = 1'b0; clr = 1'b0;
    #2;
    check("rst d0 rst_n", 32'(rst_n0), 32'h0);
    check("rst d0 ready", 32'(ready0), 32'h0);
    check("rst d0 cause", 32'(cause0), 32'h1);
    check("rst d0 state", 32'(state0), 32'h0);
    check("rst d1 rst_n", 32'(rst_n1), 32'h0);
    check("rst d1 ready", 32'(ready1), 32'h0);
    check("rst d1 cause", 32'(cause1), 32'h1);
    check("rst d1 state", 32'(state1), 32'h0);
    m0 = model_reset();
    m1 = model_reset();
    ecount = 0;
    for (int k = 0; k < 4; k++) rise0[k] = 0;
    rdy0_e = 0; rise1 = 0; rdy1_e = 0;
    #1;
    rst = 1'b0;
  endtask

  task automatic check_latency();
    for (int k = 0; k < 4; k++)
      check($sformatf("d0 rise edge ch%0d", k), 32'(rise0[k]),
            32'(c0.ss + 1 + c0.filt + c0.dly * (k + 1)));
    check("d0 ready edge", 32'(rdy0_e), 32'(c0.ss + 1 + c0.filt + c0.dly * c0.nch + 1));
    check("d1 rise edge", 32'(rise1), 32'(c1.ss + 1 + c1.filt + c1.dly));
    check("d1 ready edge", 32'(rdy1_e), 32'(c1.ss + 1 + c1.filt + c1.dly + 1));
  endtask

  initial begin
    c0 = '{4, 2, 8, 16, 32};
    c1 = '{1, 2, 1, 1, 4};
    // por, sw, clr, cycles -> rst_n, ready, cause, state after the last edge
    tbl[0]  = mk(1, 1, 0,  3, 4'b0000, 0, 2'b01, 3'd1);
    tbl[1]  = mk(1, 1, 0,  1, 4'b0000, 0, 2'b01, 3'd1);
    tbl[2]  = mk(1, 0, 0, 22, 4'b0000, 0, 2'b01, 3'd2);
    tbl[3]  = mk(1, 0, 0,  1, 4'b0001, 0, 2'b01, 3'd2);
    tbl[4]  = mk(1, 0, 0, 48, 4'b1111, 0, 2'b01, 3'd3);
    tbl[5]  = mk(1, 0, 0,  1, 4'b1111, 1, 2'b01, 3'd3);
    tbl[6]  = mk(1, 0, 1,  1, 4'b1111, 1, 2'b00, 3'd3);
    tbl[7]  = mk(1, 1, 0,  1, 4'b0000, 0, 2'b10, 3'd4);
    tbl[8]  = mk(1, 0, 0, 31, 4'b0000, 0, 2'b10, 3'd4);
    tbl[9]  = mk(1, 0, 0,  1, 4'b0000, 0, 2'b10, 3'd2);
    tbl[10] = mk(1, 0, 0, 16, 4'b0001, 0, 2'b10, 3'd2);
    tbl[11] = mk(1, 0, 0, 49, 4'b1111, 1, 2'b10, 3'd3);
    tbl[12] = mk(0, 0, 1,  2, 4'b1111, 1, 2'b00, 3'd3);
    tbl[13] = mk(0, 1, 0,  1, 4'b0000, 0, 2'b01, 3'd0);
    tbl[14] = mk(1, 0, 0, 30, 4'b0001, 0, 2'b01, 3'd2);
    tbl[15] = mk(0, 0, 0,  2, 4'b0001, 0, 2'b01, 3'd2);
    tbl[16] = mk(0, 0, 1,  1, 4'b0000, 0, 2'b01, 3'd0);
    tbl[17] = mk(1, 0, 0,  5, 4'b0000, 0, 2'b01, 3'd1);
    tbl[18] = mk(0, 0, 0,  3, 4'b0000, 0, 2'b01, 3'd0);
    tbl[19] = mk(1, 0, 0, 26, 4'b0000, 0, 2'b01, 3'd2);
    tbl[20] = mk(1, 0, 1,  1, 4'b0001, 0, 2'b00, 3'd2);
    tbl[21] = mk(1, 0, 0, 16, 4'b0011, 0, 2'b00, 3'd2);
    tbl[22] = mk(0, 0, 0,  2, 4'b0011, 0, 2'b00, 3'd2);
    tbl[23] = mk(0, 0, 0,  1, 4'b0000, 0, 2'b01, 3'd0);
    tbl[24] = mk(1, 0, 0, 76, 4'b1111, 1, 2'b01, 3'd3);

    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      por = tbl[i].por; sw = tbl[i].sw; clr = tbl[i].clr;
      repeat (tbl[i].n) step();
      sw = 1'b0; clr = 1'b0;
      check($sformatf("row%0d rst_n", i), 32'(rst_n0), 32'(tbl[i].rstn));
      check($sformatf("row%0d ready", i), 32'(ready0), 32'(tbl[i].rdy));
      check($sformatf("row%0d cause", i), 32'(cause0), 32'(tbl[i].cause));
      check($sformatf("row%0d state", i), 32'(state0), 32'(tbl[i].st));
      if (i == 5) check_latency();
    end

    for (int seg = 0; seg < 40; seg++) begin
      int len;
      por = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 100);
      for (int j = 0; j < len; j++) begin
        sw  = ($urandom_range(0, 15) == 0);
        clr = ($urandom_range(0, 31) == 0);
        step();
      end
    end

    sw = 1'b0; clr = 1'b0;
    do_reset();
    por = 1'b1;
    repeat (40) step();
    do_reset();
    por = 1'b1;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
